// File: rtl/sw_arb_2to1_pkg.sv
// Shared encodings for the 2:1 wormhole switch arbiter: flit types, FSM states
// and the one-hot mux select constants.
package sw_arb_2to1_pkg;

  localparam int TYPE_W = 2;

  typedef enum logic [1:0] {
    TYPE_NONE = 2'b00,
    TYPE_HEAD = 2'b01,
    TYPE_DATA = 2'b10,
    TYPE_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOCK0 = 2'b01,
    ST_LOCK1 = 2'b10
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_P0   = 2'b01;
  localparam logic [1:0] SEL_P1   = 2'b10;

  // The type field occupies the top TYPE_W bits of a flit of width dataw.
  function automatic logic [TYPE_W-1:0] flit_type(input logic [TYPE_W-1:0] top_bits);
    return top_bits;
  endfunction

endpackage

// File: rtl/sw_arb_2to1_rr_pick2.sv
// Two-request round-robin picker: returns a one-hot grant, ptr breaks ties.
module rr_pick2
  import sw_arb_2to1_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Tie goes to the port named by ptr; a single request wins outright.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = SEL_P0;
      2'b10:   gnt = SEL_P1;
      2'b11:   gnt = ptr ? SEL_P1 : SEL_P0;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sw_arb_2to1.sv
// Packet-level round-robin arbiter for a 2:1 router output mux; holds sel from
// HEAD to TAIL, returns per-port consume strobes and counts forwarded flits.
module sw_arb_2to1
  import sw_arb_2to1_pkg::*;
#(
  parameter int DATAW = 66,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DATAW-1:0] idata_0,
  input  logic             ivalid_0,
  input  logic [DATAW-1:0] idata_1,
  input  logic             ivalid_1,
  input  logic             ordy,
  output logic [1:0]       sel,
  output logic             ogrant_0,
  output logic             ogrant_1,
  output logic [CNTW-1:0]  flit_cnt,
  output logic             err_proto
);

  state_e            state_q;
  logic              ptr_q;
  logic [1:0]        sel_q;
  logic [CNTW-1:0]   cnt_q;
  logic [CNTW-1:0]   cnt_d;
  logic              err_q;
  logic              err_d;

  logic [TYPE_W-1:0] type0_s;
  logic [TYPE_W-1:0] type1_s;
  logic [1:0]        req_s;
  logic [1:0]        gnt_s;
  logic              bad_s;
  logic              tail0_s;
  logic              tail1_s;
  logic              unused_payload_s;

  assign type0_s = flit_type(idata_0[DATAW-1 -: TYPE_W]);
  assign type1_s = flit_type(idata_1[DATAW-1 -: TYPE_W]);
  assign unused_payload_s = ^{idata_0[DATAW-TYPE_W-1:0], idata_1[DATAW-TYPE_W-1:0]};

  assign req_s = {ivalid_1 && (type1_s == TYPE_HEAD), ivalid_0 && (type0_s == TYPE_HEAD)};

  // DATA/TAIL both have the type MSB set: a body flit on an unlocked port.
  assign bad_s = (state_q == ST_IDLE) &&
                 ((ivalid_0 && type0_s[1]) || (ivalid_1 && type1_s[1]));

  assign ogrant_0 = (state_q == ST_LOCK0) && ivalid_0 && ordy;
  assign ogrant_1 = (state_q == ST_LOCK1) && ivalid_1 && ordy;

  assign tail0_s = ogrant_0 && (type0_s == TYPE_TAIL);
  assign tail1_s = ogrant_1 && (type1_s == TYPE_TAIL);

  assign cnt_d = ((ogrant_0 || ogrant_1) && (cnt_q != {CNTW{1'b1}})) ? cnt_q + CNTW'(1) : cnt_q;
  assign err_d = err_q || bad_s;

  rr_pick2 u_pick (
    .req (req_s),
    .ptr (ptr_q),
    .gnt (gnt_s)
  );

  // Arbitration FSM; sel is registered alongside the state it decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      sel_q   <= SEL_NONE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      case (state_q)
        ST_IDLE: begin
          if (gnt_s == SEL_P0) begin
            state_q <= ST_LOCK0;
            sel_q   <= SEL_P0;
          end else if (gnt_s == SEL_P1) begin
            state_q <= ST_LOCK1;
            sel_q   <= SEL_P1;
          end else begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_NONE;
          end
        end
        ST_LOCK0: begin
          if (tail0_s) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_NONE;
            ptr_q   <= 1'b1;
          end else begin
            sel_q   <= SEL_P0;
          end
        end
        ST_LOCK1: begin
          if (tail1_s) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_NONE;
            ptr_q   <= 1'b0;
          end else begin
            sel_q   <= SEL_P1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sel_q   <= SEL_NONE;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign flit_cnt  = cnt_q;
  assign err_proto = err_q;

endmodule
